// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises and debounces a board reset gated on PLL lock,
// then releases NUM_RESETS active-high resets in ascending order, STAGE_DELAY apart.
module reset_sequencer #(
  parameter int NUM_RESETS     = 4,
  parameter int SYNC_STAGES    = 4,
  parameter int DEBOUNCE_BITS  = 8,
  parameter int STAGE_DELAY    = 16,
  parameter int REVERSE_ASSERT = 1
) (
  input  logic                  clock,
  input  logic                  areset_n,
  input  logic                  locked,
  input  logic                  soft_req,
  output logic [NUM_RESETS-1:0] reset,
  output logic                  done,
  output logic                  busy
);
  localparam int IDX_W = (NUM_RESETS > 1) ? $clog2(NUM_RESETS) : 1;
  localparam int DC_W  = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;

  localparam logic [IDX_W-1:0]         IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0]         IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]         IDX_LAST  = IDX_W'(NUM_RESETS - 1);
  localparam logic [IDX_W-1:0]         IDX_REV0  = IDX_W'(NUM_RESETS - 2);
  localparam logic [DC_W-1:0]          DC_ZERO   = DC_W'(0);
  localparam logic [DC_W-1:0]          DC_ONE    = DC_W'(1);
  localparam logic [DC_W-1:0]          DC_LAST   = DC_W'(STAGE_DELAY - 1);
  localparam logic [DEBOUNCE_BITS-1:0] DB_ZERO   = DEBOUNCE_BITS'(0);
  localparam logic [DEBOUNCE_BITS-1:0] DB_ONE    = DEBOUNCE_BITS'(1);
  localparam logic [DEBOUNCE_BITS-1:0] DB_LAST   = {DEBOUNCE_BITS{1'b1}};
  localparam logic [NUM_RESETS-1:0]    RST_ALL   = {NUM_RESETS{1'b1}};

  localparam logic [1:0] S_HOLD   = 2'd0;
  localparam logic [1:0] S_SEQ    = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_ASSERT = 2'd3;

  logic [SYNC_STAGES-1:0]   sync_r;
  logic [1:0]               lock_r;
  logic [1:0]               state_r,  state_nx;
  logic [DEBOUNCE_BITS-1:0] dbcnt_r,  dbcnt_nx;
  logic [DC_W-1:0]          dcnt_r,   dcnt_nx;
  logic [IDX_W-1:0]         idx_r,    idx_nx;
  logic [NUM_RESETS-1:0]    reset_r,  reset_nx;
  logic                     done_r,   done_nx;
  logic                     busy_r,   busy_nx;
  logic                     rst_sync;
  logic                     locked_s;
  logic                     go_s;

  assign rst_sync = sync_r[SYNC_STAGES-1];
  assign locked_s = lock_r[1];
  assign go_s     = !rst_sync && locked_s;

  // Reset deassertion synchroniser and lock qualifier synchroniser.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      sync_r <= {SYNC_STAGES{1'b1}};
      lock_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b0};
      lock_r <= {lock_r[0], locked};
    end
  end

  // Sequencer next-state: lock loss beats soft_req, which beats counting.
  always_comb begin
    state_nx = state_r;
    dbcnt_nx = dbcnt_r;
    dcnt_nx  = dcnt_r;
    idx_nx   = idx_r;
    reset_nx = reset_r;
    case (state_r)
      S_HOLD: begin
        reset_nx = RST_ALL;
        dcnt_nx  = DC_ZERO;
        idx_nx   = IDX_ZERO;
        if (!go_s) begin
          dbcnt_nx = DB_ZERO;
        end else if (dbcnt_r == DB_LAST) begin
          state_nx = S_SEQ;
          dbcnt_nx = DB_ZERO;
        end else begin
          dbcnt_nx = dbcnt_r + DB_ONE;
        end
      end
      S_SEQ: begin
        if (!locked_s || soft_req) begin
          state_nx = S_HOLD;
          reset_nx = RST_ALL;
          dbcnt_nx = DB_ZERO;
          dcnt_nx  = DC_ZERO;
          idx_nx   = IDX_ZERO;
        end else if (dcnt_r == DC_LAST) begin
          reset_nx[idx_r] = 1'b0;
          dcnt_nx         = DC_ZERO;
          if (idx_r == IDX_LAST) begin
            state_nx = S_RUN;
          end else begin
            idx_nx = idx_r + IDX_ONE;
          end
        end else begin
          dcnt_nx = dcnt_r + DC_ONE;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_nx = S_HOLD;
          reset_nx = RST_ALL;
          dbcnt_nx = DB_ZERO;
          dcnt_nx  = DC_ZERO;
          idx_nx   = IDX_ZERO;
        end else if (soft_req && (REVERSE_ASSERT != 0) && (NUM_RESETS > 1)) begin
          state_nx             = S_ASSERT;
          reset_nx[IDX_LAST]   = 1'b1;
          idx_nx               = IDX_REV0;
          dcnt_nx              = DC_ZERO;
        end else if (soft_req) begin
          state_nx = S_HOLD;
          reset_nx = RST_ALL;
          dbcnt_nx = DB_ZERO;
          dcnt_nx  = DC_ZERO;
          idx_nx   = IDX_ZERO;
        end else begin
          reset_nx = {NUM_RESETS{1'b0}};
        end
      end
      S_ASSERT: begin
        if (!locked_s) begin
          state_nx = S_HOLD;
          reset_nx = RST_ALL;
          dbcnt_nx = DB_ZERO;
          dcnt_nx  = DC_ZERO;
          idx_nx   = IDX_ZERO;
        end else if (dcnt_r == DC_LAST) begin
          reset_nx[idx_r] = 1'b1;
          dcnt_nx         = DC_ZERO;
          if (idx_r == IDX_ZERO) begin
            state_nx = S_HOLD;
            dbcnt_nx = DB_ZERO;
          end else begin
            idx_nx = idx_r - IDX_ONE;
          end
        end else begin
          dcnt_nx = dcnt_r + DC_ONE;
        end
      end
      default: begin
        state_nx = S_HOLD;
        reset_nx = RST_ALL;
        dbcnt_nx = DB_ZERO;
        dcnt_nx  = DC_ZERO;
        idx_nx   = IDX_ZERO;
      end
    endcase
    done_nx = (state_nx == S_RUN);
    busy_nx = (state_nx == S_SEQ) || (state_nx == S_ASSERT);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_r <= S_HOLD;
      dbcnt_r <= DB_ZERO;
      dcnt_r  <= DC_ZERO;
      idx_r   <= IDX_ZERO;
      reset_r <= RST_ALL;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      dbcnt_r <= dbcnt_nx;
      dcnt_r  <= dcnt_nx;
      idx_r   <= idx_nx;
      reset_r <= reset_nx;
      done_r  <= done_nx;
      busy_r  <= busy_nx;
    end
  end

  assign reset = reset_r;
  assign done  = done_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: two sequencers (reverse and all-at-once reassertion) with
// N=3, DB=3, SD=2, SYNC=4, sharing clock, areset_n and locked.
module tb_reset_sequencer;
  logic       clock;
  logic       areset_n;
  logic       locked;
  logic       soft_rev;
  logic       soft_all;
  logic [2:0] reset_rev;
  logic [2:0] reset_all;
  logic       done_rev, busy_rev, done_all, busy_all;

  int cyc    = 0;
  int total  = 0;
  int passed = 0;
  int failed = 0;

  reset_sequencer #(.NUM_RESETS(3), .SYNC_STAGES(4), .DEBOUNCE_BITS(3),
                    .STAGE_DELAY(2), .REVERSE_ASSERT(1)) u_rev (
    .clock(clock), .areset_n(areset_n), .locked(locked), .soft_req(soft_rev),
    .reset(reset_rev), .done(done_rev), .busy(busy_rev));

  reset_sequencer #(.NUM_RESETS(3), .SYNC_STAGES(4), .DEBOUNCE_BITS(3),
                    .STAGE_DELAY(2), .REVERSE_ASSERT(0)) u_all (
    .clock(clock), .areset_n(areset_n), .locked(locked), .soft_req(soft_all),
    .reset(reset_all), .done(done_all), .busy(busy_all));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not reach its end (cyc=%0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_rev(input string tag, input logic [2:0] r, input logic d, input logic b);
    check({tag, " rev.reset"}, 32'(reset_rev), 32'(r));
    check({tag, " rev.done"},  32'(done_rev),  32'(d));
    check({tag, " rev.busy"},  32'(busy_rev),  32'(b));
  endtask

  task automatic expect_all(input string tag, input logic [2:0] r, input logic d, input logic b);
    check({tag, " all.reset"}, 32'(reset_all), 32'(r));
    check({tag, " all.done"},  32'(done_all),  32'(d));
    check({tag, " all.busy"},  32'(busy_all),  32'(b));
  endtask

  // Advance to 1 time unit after rising edge number e.
  task automatic goto(input int e);
    while (cyc < e) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    areset_n = 1'b0;
    locked   = 1'b1;
    soft_rev = 1'b0;
    soft_all = 1'b0;

    // Bring-up: release after edge 3, rst_sync low after edge 7, T0 = 8.
    goto(3);
    expect_rev("in_reset", 3'b111, 1'b0, 1'b0);
    expect_all("in_reset", 3'b111, 1'b0, 1'b0);
    areset_n = 1'b1;
    goto(6);   check("rst_sync_held", 32'(u_rev.rst_sync), 32'd1);
    goto(7);   check("rst_sync_fell", 32'(u_rev.rst_sync), 32'd0);
    goto(14);  expect_rev("boot_T0+6", 3'b111, 1'b0, 1'b0);
    goto(15);  expect_rev("boot_T0+7", 3'b111, 1'b0, 1'b1);
    goto(16);  expect_rev("boot_T0+8", 3'b111, 1'b0, 1'b1);
    goto(17);  expect_rev("boot_T0+9", 3'b110, 1'b0, 1'b1);
    expect_all("boot_T0+9", 3'b110, 1'b0, 1'b1);
    goto(18);  expect_rev("boot_T0+10", 3'b110, 1'b0, 1'b1);
    goto(19);  expect_rev("boot_T0+11", 3'b100, 1'b0, 1'b1);
    goto(20);  expect_rev("boot_T0+12", 3'b100, 1'b0, 1'b1);
    goto(21);  expect_rev("boot_T0+13", 3'b000, 1'b1, 1'b0);
    expect_all("boot_T0+13", 3'b000, 1'b1, 1'b0);

    // Reverse reassertion: soft_rev sampled at edge 24, HOLD at 28, T0 = 29.
    goto(23);  soft_rev = 1'b1;
    goto(24);  soft_rev = 1'b0;
    expect_rev("rev_S", 3'b100, 1'b0, 1'b1);
    goto(25);  expect_rev("rev_S+1", 3'b100, 1'b0, 1'b1);
    goto(26);  expect_rev("rev_S+2", 3'b110, 1'b0, 1'b1);
    goto(27);  expect_rev("rev_S+3", 3'b110, 1'b0, 1'b1);
    goto(28);  expect_rev("rev_S+4", 3'b111, 1'b0, 1'b0);
    expect_all("rev_S+4 other", 3'b000, 1'b1, 1'b0);
    goto(37);  expect_rev("rev_rel_early", 3'b111, 1'b0, 1'b1);
    goto(38);  expect_rev("rev_rel0", 3'b110, 1'b0, 1'b1);
    goto(40);  expect_rev("rev_rel1", 3'b100, 1'b0, 1'b1);
    goto(42);  expect_rev("rev_rel2", 3'b000, 1'b1, 1'b0);

    // All-at-once reassertion: soft_all sampled at edge 44, T0 = 45.
    goto(43);  soft_all = 1'b1;
    goto(44);  soft_all = 1'b0;
    expect_all("all_U", 3'b111, 1'b0, 1'b0);
    expect_rev("all_U other", 3'b000, 1'b1, 1'b0);
    goto(53);  expect_all("all_rel_early", 3'b111, 1'b0, 1'b1);
    goto(54);  expect_all("all_rel0", 3'b110, 1'b0, 1'b1);
    goto(58);  expect_all("all_rel2", 3'b000, 1'b1, 1'b0);

    // Lock loss mid-SEQ: u_all released bit 0 at edge 70 as locked is sampled low.
    goto(59);  soft_all = 1'b1;
    goto(60);  soft_all = 1'b0;
    goto(69);  locked = 1'b0;
    goto(70);  expect_all("lock_rel0", 3'b110, 1'b0, 1'b1);
    goto(71);  expect_all("lock_+1", 3'b110, 1'b0, 1'b1);
    expect_rev("lock_+1 run", 3'b000, 1'b1, 1'b0);
    goto(72);  expect_all("lock_lost", 3'b111, 1'b0, 1'b0);
    expect_rev("lock_lost", 3'b111, 1'b0, 1'b0);

    // Restore lock (T0 = 77), then a one-cycle go drop seen at 82: new T0 = 83.
    goto(74);  locked = 1'b1;
    goto(79);  locked = 1'b0;
    goto(80);  locked = 1'b1;
    goto(86);  expect_rev("glitch_old_T0+9", 3'b111, 1'b0, 1'b0);
    expect_all("glitch_old_T0+9", 3'b111, 1'b0, 1'b0);
    goto(91);  expect_rev("glitch_T0+8", 3'b111, 1'b0, 1'b1);
    goto(92);  expect_rev("glitch_T0+9", 3'b110, 1'b0, 1'b1);
    expect_all("glitch_T0+9", 3'b110, 1'b0, 1'b1);
    goto(94);  expect_rev("glitch_T0+11", 3'b100, 1'b0, 1'b1);
    goto(96);  expect_rev("glitch_T0+13", 3'b000, 1'b1, 1'b0);
    expect_all("glitch_T0+13", 3'b000, 1'b1, 1'b0);

    // Short areset_n pulse mid-ASSERT after edge 101: rst_sync low after 105, T0 = 106.
    goto(99);  soft_rev = 1'b1;
    goto(100); soft_rev = 1'b0;
    expect_rev("ar_assert", 3'b100, 1'b0, 1'b1);
    goto(101); expect_rev("ar_assert+1", 3'b100, 1'b0, 1'b1);
    #1 areset_n = 1'b0;
    #1 expect_rev("ar_async", 3'b111, 1'b0, 1'b0);
    expect_all("ar_async", 3'b111, 1'b0, 1'b0);
    #1 areset_n = 1'b1;
    goto(104); check("ar_rst_sync_held", 32'(u_rev.rst_sync), 32'd1);
    goto(105); check("ar_rst_sync_fell", 32'(u_rev.rst_sync), 32'd0);
    goto(110); expect_rev("ar_debounce", 3'b111, 1'b0, 1'b0);
    goto(114); expect_rev("ar_T0+8", 3'b111, 1'b0, 1'b1);
    goto(115); expect_rev("ar_T0+9", 3'b110, 1'b0, 1'b1);
    goto(118); expect_rev("ar_T0+12", 3'b100, 1'b0, 1'b1);
    goto(119); expect_rev("ar_T0+13", 3'b000, 1'b1, 1'b0);
    expect_all("ar_T0+13", 3'b000, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
